buffer_writer: RTL and testbench

Write-side controller for the 1024 x 16 sample buffer: accepts a stream of 16-bit samples over a valid/ready handshake and produces the buffer write strobe, write address and write data. It fills one frame of programmable length starting at address 0, then raises `done` so the read-address side can start draining. It sits between the sample source and the buffer's write port, opposite the read-address generator on the read port.

---
 rtl/buffer_writer_pkg.sv | 13 +
 rtl/buffer_writer_counter.sv | 35 +++
 rtl/buffer_writer.sv | 108 ++++++++++
 tb/tb_buffer_writer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/buffer_writer_pkg.sv
// Shared constants for the 1024 x 16 sample buffer and the write-side FSM encoding.
// The read-address side imports the same geometry.
package buffer_writer_pkg;

  localparam int DEPTH     = 1024;
  localparam int LOG_DEPTH = 10;
  localparam int WIDTH     = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/buffer_writer_counter.sv
// Frame sample counter; one bit wider than the address so a full-depth frame
// can report a count equal to DEPTH.
module write_addr_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // Clear wins over increment so a new frame always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/buffer_writer.sv
// Write-side controller for the sample buffer: fills one frame of programmable
// length from a valid/ready stream, then holds done until the next start.
module buffer_writer
  import buffer_writer_pkg::*;
#(
  parameter int DEPTH     = buffer_writer_pkg::DEPTH,
  parameter int LOG_DEPTH = buffer_writer_pkg::LOG_DEPTH,
  parameter int WIDTH     = buffer_writer_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LOG_DEPTH:0]   length,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wen,
  output logic [LOG_DEPTH-1:0] waddr,
  output logic [WIDTH-1:0]     wdata,
  output logic [LOG_DEPTH:0]   count,
  output logic                 done
);

  localparam int LW = LOG_DEPTH + 1;
  localparam logic [LW-1:0] FULL_LEN = LW'(DEPTH);

  logic [1:0]           state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        cnt, cnt_nxt;
  logic                 accept, last, clr;
  logic                 wen_q;
  logic [LOG_DEPTH-1:0] waddr_q;
  logic [WIDTH-1:0]     wdata_q;

  // Ready depends only on registered state, never on in_valid.
  assign in_ready = (state_q == ST_FILL);
  assign accept   = in_valid & in_ready;
  assign cnt_nxt  = cnt + 1'b1;
  assign last     = accept && (cnt_nxt == len_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FILL;
          clr     = 1'b1;
          // Zero or oversize lengths mean a full-depth frame.
          if ((length == '0) || (length > FULL_LEN)) begin
            len_d = FULL_LEN;
          end else begin
            len_d = length;
          end
        end
      end
      ST_FILL: begin
        if (last) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= FULL_LEN;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  write_addr_counter #(
    .W(LW)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .inc_i  (accept),
    .count_o(cnt)
  );

  // Write port registers: one cycle behind the accepting edge; hold on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= accept;
      if (accept) begin
        waddr_q <= cnt[LOG_DEPTH-1:0];
        wdata_q <= in_data;
      end
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign count = cnt;
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_buffer_writer.sv
// Directed bench for buffer_writer: expected writes are queued as beats are
// driven and retired by a write-port monitor.
module tb_buffer_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] length;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wen;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic [10:0] count;
  logic        done;

  int tests = 0;
  int fails = 0;
  logic [25:0] sb[$];

  always #5 clk = ~clk;

  buffer_writer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .length  (length),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .count   (count),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    logic [25:0] e;
    if (wen === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_wen_addr", 32'(waddr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("waddr", 32'(waddr), 32'(e[25:16]));
        chk("wdata", 32'(wdata), 32'(e[15:0]));
      end
    end
  end

  // Called just after a rising edge; returns just after the next one.
  task automatic beat(input logic v, input logic [15:0] d, input logic exp_rdy,
                      input logic exp_acc, input int a);
    logic [9:0] a10;
    a10      = a[9:0];
    in_valid = v;
    in_data  = d;
    if (exp_acc) sb.push_back({a10, d});
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input logic [10:0] len);
    in_valid = 1'b0;
    start    = 1'b1;
    length   = len;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_done_low", 32'(done), 32'd0);
    chk("start_count_clr", 32'(count), 32'd0);
    chk("start_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic end_frame(input int n, input int last_addr);
    in_valid = 1'b0;
    @(negedge clk);
    chk("end_done", 32'(done), 32'd1);
    chk("end_ready", 32'(in_ready), 32'd0);
    chk("end_count", 32'(count), 32'(n));
    chk("end_last_wen", 32'(wen), 32'd1);
    chk("end_last_addr", 32'(waddr), 32'(last_addr));
    @(posedge clk); #1;
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    length   = '0;
    in_data  = '0;
    in_valid = 1'b0;
    #12;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(in_ready), 32'd0);

    // Reset mid-frame.
    start_frame(11'd8);
    for (int i = 0; i < 3; i++) beat(1'b1, 16'h7000 + 16'(i), 1'b1, 1'b1, i);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_wen", 32'(wen), 32'd0);
    chk("midrst_waddr", 32'(waddr), 32'd0);
    chk("midrst_wdata", 32'(wdata), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1'b1, 16'h1111, 1'b0, 1'b0, 0);
    start_frame(11'd2);
    beat(1'b1, 16'hB000, 1'b1, 1'b1, 0);
    beat(1'b1, 16'hB001, 1'b1, 1'b1, 1);
    end_frame(2, 1);

    // Basic frame.
    start_frame(11'd4);
    for (int i = 0; i < 4; i++) beat(1'b1, 16'hA000 + 16'(i), 1'b1, 1'b1, i);
    end_frame(4, 3);

    // Bubbles: valid pattern 1,0,0,1,0,1.
    start_frame(11'd3);
    beat(1'b1, 16'hC100, 1'b1, 1'b1, 0);
    beat(1'b0, 16'hDEAD, 1'b1, 1'b0, 0);
    chk("bubble_wen0", 32'(wen), 32'd0);
    chk("bubble_hold_addr", 32'(waddr), 32'd0);
    beat(1'b0, 16'hDEAD, 1'b1, 1'b0, 0);
    beat(1'b1, 16'hC101, 1'b1, 1'b1, 1);
    beat(1'b0, 16'hDEAD, 1'b1, 1'b0, 0);
    chk("bubble_hold_data", 32'(wdata), 32'hC101);
    beat(1'b1, 16'hC102, 1'b1, 1'b1, 2);
    end_frame(3, 2);

    // Full depth via length 0; the 1025th beat must be refused.
    start_frame(11'd0);
    for (int i = 0; i < 1024; i++) beat(1'b1, 16'(i) ^ 16'h5A5A, 1'b1, 1'b1, i);
    in_data = 16'hFFFF;
    @(negedge clk);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd1024);
    chk("full_last_addr", 32'(waddr), 32'd1023);
    chk("full_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_no_extra_wen", 32'(wen), 32'd0);
    chk("full_count_hold", 32'(count), 32'd1024);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    // Start during FILL is ignored; start in DONE restarts.
    start_frame(11'd5);
    start  = 1'b1;
    length = 11'd2;
    beat(1'b1, 16'hE000, 1'b1, 1'b1, 0);
    start = 1'b0;
    for (int i = 1; i < 5; i++) beat(1'b1, 16'hE000 + 16'(i), 1'b1, 1'b1, i);
    end_frame(5, 4);
    start_frame(11'd2);
    beat(1'b1, 16'hF000, 1'b1, 1'b1, 0);
    beat(1'b1, 16'hF001, 1'b1, 1'b1, 1);
    end_frame(2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
